// File: rtl/fp_conv_arbiter.sv
// fp_conv_arbiter
//   Several adder-tree lanes share one fixed-point to FP32 converter. A
//   round-robin arbiter grants one lane per cycle. The granted value goes
//   through a two-register pipeline: S1 holds the raw operand and S2 is the
//   output register that holds the converted FP32 result.
//
// Ports
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   req_valid/ready    per-requester handshake; req_ready is one-hot or zero
//   req_fixed          packed two's-complement sums, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_exp            packed unbiased block exponents, lane i at [i*8 +: 8]
//   out_valid/ready    result handshake
//   out_fp32, out_id   converted value and the index of the lane that produced it
//   out_count          completed output transfers, wraps at 2^32
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high. A valid request may be withdrawn while its ready is low.
// Ready depends on valid and on the pipeline state only. Producers must
// not make valid depend on ready.
module fp_conv_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 51,
   parameter int FIXED_POINT = 46,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_fixed,
   input  logic [NUM_REQ*8-1:0]          req_exp,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_fp32,
   output logic [ID_W-1:0]               out_id,
   output logic [31:0]                   out_count
);

   localparam int P_W = $clog2(DATA_WIDTH);

   // Arbitration state
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic                  grant_found;
   logic [ID_W-1:0]       grant_idx;
   int                    cand;

   // Pipeline state
   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_fixed_q;
   logic [7:0]            s1_exp_q;
   logic [ID_W-1:0]       s1_id_q;
   logic                  out_valid_q;
   logic [31:0]           out_fp32_q;
   logic [ID_W-1:0]       out_id_q;
   logic [31:0]           out_count_q, out_count_d;

   // Flow control
   logic                  s2_load;
   logic                  s1_accept;
   logic                  xfer;
   logic                  out_xfer;

   // Conversion datapath
   logic [DATA_WIDTH-1:0] mag;
   logic [P_W-1:0]        p_idx;
   logic [7:0]            exp_field;
   logic [22:0]           mant;
   logic [31:0]           conv_fp;

   assign s2_load   = !out_valid_q || out_ready;
   assign s1_accept = !s1_valid_q || s2_load;
   assign out_xfer  = out_valid_q && out_ready;

   // Search order is ptr+1, ptr+2, ... and wraps modulo NUM_REQ. NUM_REQ
   // need not be a power of two, so the wrap is done explicitly.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(cand);
         end
      end
   end

   // Ready is held low during reset. It comes back in the first cycle
   // after rst falls.
   always_comb begin
      req_ready = '0;
      if (!rst && grant_found && s1_accept) req_ready[grant_idx] = 1'b1;
   end

   assign xfer  = !rst && grant_found && s1_accept;
   assign ptr_d = xfer ? grant_idx : ptr_q;

   // Magnitude fits in DATA_WIDTH bits unsigned, including 2^(DATA_WIDTH-1)
   // for the most-negative input.
   assign mag = s1_fixed_q[DATA_WIDTH-1] ? (~s1_fixed_q + DATA_WIDTH'(1)) : s1_fixed_q;

   always_comb begin
      p_idx = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (mag[i]) p_idx = P_W'(i);
      end
   end

   // The 8-bit sum wraps modulo 256.
   assign exp_field = s1_exp_q + 8'(p_idx) - 8'(FIXED_POINT) + 8'd127;
   // (mag * 2^23) >> p leaves the leading one at bit 23 and the truncated
   // fraction in bits [22:0]. This one shift covers both the left-shift case
   // (p < 23) and the right-shift case (p >= 23).
   assign mant      = 23'({mag, 23'b0} >> p_idx);
   assign conv_fp   = (mag == '0) ? 32'h0000_0000
                                  : {s1_fixed_q[DATA_WIDTH-1], exp_field, mant};

   assign out_count_d = out_xfer ? out_count_q + 32'd1 : out_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= ID_W'(NUM_REQ - 1);
         s1_valid_q  <= 1'b0;
         s1_fixed_q  <= '0;
         s1_exp_q    <= '0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_fp32_q  <= '0;
         out_id_q    <= '0;
         out_count_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_count_q <= out_count_d;
         if (s1_accept) begin
            s1_valid_q <= xfer;
            if (xfer) begin
               s1_fixed_q <= req_fixed[grant_idx*DATA_WIDTH +: DATA_WIDTH];
               s1_exp_q   <= req_exp[grant_idx*8 +: 8];
               s1_id_q    <= grant_idx;
            end
         end
         // The output data registers load only when a real item arrives.
         // A bubble leaves the last result in place.
         if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_fp32_q <= conv_fp;
               out_id_q   <= s1_id_q;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_fp32  = out_fp32_q;
   assign out_id    = out_id_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_fp_conv_arbiter.sv
// Bench for fp_conv_arbiter. The reference model uses double-precision real
// arithmetic. It computes value = +/-mag * 2^(exp-46), which is exact in a
// double. The FP32 fields are then taken from the double's bit pattern,
// with the mantissa truncated.
module tb_fp_conv_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 51;
   localparam int FP      = 46;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*DW-1:0] req_fixed;
   logic [NUM_REQ*8-1:0]  req_exp;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_fp32;
   logic [ID_W-1:0]       out_id;
   logic [31:0]           out_count;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: {id, fp32} in acceptance order
   logic [ID_W+31:0] exp_q[$];
   int               mptr;
   int               acc_cnt;
   logic [31:0]      m_count;
   logic             prev_hold;
   logic [ID_W+31:0] prev_data;

   fp_conv_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .FIXED_POINT(FP)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_fixed (req_fixed),
      .req_exp   (req_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fp32  (out_fp32),
      .out_id    (out_id),
      .out_count (out_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_conv(input logic [DW-1:0] fx, input logic [7:0] ex);
      longint      m;
      real         r;
      logic [63:0] d;
      int          e;
      int          fe;
      logic [31:0] fev;
      if (fx[DW-1]) m = (longint'(1) <<< DW) - longint'({13'b0, fx});
      else          m = longint'({13'b0, fx});
      if (m == 0) return 32'h0000_0000;
      r = real'(m);
      e = int'($signed(ex)) - FP;
      if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else       for (int i = 0; i < -e; i++) r = r / 2.0;
      d   = $realtobits(r);
      fe  = int'(d[62:52]) - 1023 + 127;
      fev = fe;
      return {fx[DW-1], fev[7:0], d[51:29]};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   // Sampled 2 time units after the falling edge. By then the inputs are
   // set for the next rising edge and the outputs reflect the previous one.
   always begin
      int                 n;
      logic               can;
      logic               found;
      int                 idx;
      logic [NUM_REQ-1:0] want_rdy;
      logic [ID_W+31:0]   e;
      logic [ID_W-1:0]    id_v;
      @(negedge clk);
      #2;
      if (rst) begin
         check("rst_ready", {60'b0, req_ready}, 64'd0);
         check("rst_out_valid", {63'b0, out_valid}, 64'd0);
         exp_q.delete();
         mptr      = NUM_REQ - 1;
         m_count   = 32'd0;
         prev_hold = 1'b0;
      end else begin
         n   = exp_q.size();
         can = (n < 2) || out_ready;
         want_rdy = '0;
         found    = 1'b0;
         if (can) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = (mptr + k) % NUM_REQ;
               if (!found && req_valid[idx]) begin
                  found         = 1'b1;
                  want_rdy[idx] = 1'b1;
               end
            end
         end
         check("req_ready", {60'b0, req_ready}, {60'b0, want_rdy});
         check("out_count", {32'b0, out_count}, {32'b0, m_count});
         if (prev_hold) begin
            check("hold_valid", {63'b0, out_valid}, 64'd1);
            check("hold_data", {30'b0, out_id, out_fp32}, {30'b0, prev_data});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", {63'b0, out_valid}, 64'd0);
            else begin
               e = exp_q.pop_front();
               check("out_data", {30'b0, out_id, out_fp32}, {30'b0, e});
            end
            m_count = m_count + 32'd1;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               id_v = ID_W'(i);
               exp_q.push_back({id_v, model_conv(req_fixed[i*DW +: DW], req_exp[i*8 +: 8])});
               mptr = i;
               acc_cnt++;
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = {out_id, out_fp32};
      end
   end

   // ---------------- drivers ----------------
   function automatic logic [DW-1:0] rand_fixed();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return DW'(1) << (DW - 1);
         2:       return DW'($urandom_range(1, 1000));
         default: return w[DW-1:0];
      endcase
   endfunction

   function automatic logic [7:0] rand_exp();
      int e;
      e = int'($urandom_range(0, 20)) - 10;
      return 8'(e);
   endfunction

   task automatic drive_lane(input int i, input logic v, input logic [DW-1:0] fx, input logic [7:0] ex);
      req_valid[i]         = v;
      req_fixed[i*DW +: DW] = fx;
      req_exp[i*8 +: 8]    = ex;
   endtask

   task automatic drive_all_random(input logic all_valid);
      for (int i = 0; i < NUM_REQ; i++)
         drive_lane(i, all_valid ? 1'b1 : 1'($urandom_range(0, 1)), rand_fixed(), rand_exp());
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         req_valid = '0;
         out_ready = 1'b1;
      end
   endtask

   // One request into an empty pipeline. Checks that out_valid is still low
   // one cycle later and that the result is present exactly two cycles later.
   task automatic single_req(input int id, input logic [DW-1:0] fx, input logic [7:0] ex,
                             input logic [31:0] want, input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      drive_lane(id, 1'b1, fx, ex);
      @(negedge clk);
      req_valid = '0;
      #3;
      check({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
      @(negedge clk);
      #3;
      check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
      check({tag, "_fp32"}, {32'b0, out_fp32}, {32'b0, want});
      check({tag, "_id"}, {62'b0, out_id}, 64'(id));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] c0;
      int          a0;
      rst       = 1'b1;
      req_valid = '0;
      req_fixed = '0;
      req_exp   = '0;
      out_ready = 1'b1;
      acc_cnt   = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_fp32", {32'b0, out_fp32}, 64'd0);
      check("reset_count", {32'b0, out_count}, 64'd0);
      rst = 1'b0;

      // Directed conversions
      single_req(2, DW'(1) << 46, 8'd0, 32'h3F80_0000, "one");
      @(negedge clk);
      #3;
      check("first_count", {32'b0, out_count}, 64'd1);
      single_req(1, DW'(3) << 45, 8'd1, 32'h4040_0000, "three");
      single_req(3, -(DW'(1) << 46), 8'd0, 32'hBF80_0000, "minus_one");
      single_req(0, DW'(1), 8'd0, 32'h2880_0000, "lsb");
      single_req(2, DW'(0), 8'd5, 32'h0000_0000, "zero");
      single_req(1, DW'(1) << (DW - 1), 8'd2, 32'hC280_0000, "most_neg");
      idle(3);

      // Full load, no backpressure: one result per cycle after fill
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         drive_all_random(1'b1);
         if (c == 3) begin
            #3;
            c0 = out_count;
         end
      end
      @(negedge clk);
      #3;
      check("no_bubble", {32'b0, out_count - c0}, 64'd9);
      idle(4);

      // Full load, output stalled for 6 cycles: only 2 items accepted
      a0 = acc_cnt;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         drive_all_random(1'b1);
      end
      @(negedge clk);
      #3;
      check("bp_accepts", 64'(acc_cnt - a0), 64'd2);
      check("bp_ready", {60'b0, req_ready}, 64'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         drive_all_random(1'b1);
      end
      idle(4);

      // Reset with two items in flight
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         drive_all_random(1'b1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {63'b0, out_valid}, 64'd0);
      check("arst_count", {32'b0, out_count}, 64'd0);
      check("arst_ready", {60'b0, req_ready}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_grant", {60'b0, req_ready}, 64'd1);
      idle(5);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         drive_all_random(1'b0);
         out_ready = ($urandom_range(0, 9) < 7);
      end
      idle(6);
      @(negedge clk);
      #3;
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
